// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory stage.
// Imported by the stage, its timer and its memory interface.
package mem_stage_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_REG_W    = 3;
  localparam int DEF_MAX_WAIT = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ERR    = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = S_IDLE,
    ACCESS = S_ACCESS,
    ERR    = S_ERR
  } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data memory req/ack bus between the memory stage and memory.
// Request side is the master; memory is the slave.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              mem_req;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/mem_stage_wait_timer.sv
// Counts ACCESS cycles without ack; saturates at MAX_WAIT-1.
// expired marks the last cycle allowed before a timeout.
module mem_wait_timer
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: load/store over a req/ack bus, MEM/WB register,
// upstream stall and forwarding value back to execute.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_W    = DEF_REG_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic [REG_W-1:0]  ex_wr_reg,
  input  logic              ex_reg_write,
  input  logic              ex_halt,
  mem_stage_if.master       mem,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_halt,
  output logic              wb_mem_to_reg,
  output logic [REG_W-1:0]  wb_wr_reg,
  output logic [DATA_W-1:0] wb_alu,
  output logic [DATA_W-1:0] wb_rdata,
  output logic [DATA_W-1:0] fwd_data,
  output logic              err
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              halt;
    logic              mem_to_reg;
    logic [REG_W-1:0]  wr_reg;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata;
  } wb_t;

  function automatic wb_t bubble(wb_t w);
    wb_t b;
    b           = w;
    b.valid     = 1'b0;
    b.reg_write = 1'b0;
    b.halt      = 1'b0;
    return b;
  endfunction

  state_t            state_q, state_d;
  wb_t               wb_q, wb_d, ex_pass;
  logic              err_q, err_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              access, mis;
  logic              stall_c;
  logic              tmr_clear, tmr_en, tmr_expired;

  assign access = ex_valid & (ex_mem_read | ex_mem_write);
  assign mis    = access & ex_alu_out[0];

  assign ex_pass = '{
    valid:      ex_valid,
    reg_write:  ex_reg_write,
    halt:       ex_halt,
    mem_to_reg: 1'b0,
    wr_reg:     ex_wr_reg,
    alu:        ex_alu_out,
    rdata:      wb_q.rdata
  };

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wb_d      = wb_q;
    stall_c   = 1'b0;
    tmr_clear = 1'b1;
    tmr_en    = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        stall_c = access;
        if (mis) begin
          err_d   = 1'b1;
          state_d = ERR;
          wb_d    = bubble(wb_q);
        end else if (access) begin
          addr_d  = ex_alu_out;
          wdata_d = ex_write_data;
          wr_d    = ex_mem_write;
          state_d = ACCESS;
          wb_d    = bubble(wb_q);
        end else begin
          wb_d = ex_pass;
        end
      end
      (state_q == ACCESS): begin
        stall_c   = !mem.mem_ack;
        tmr_clear = 1'b0;
        if (mem.mem_ack) begin
          wb_d            = ex_pass;
          wb_d.rdata      = mem.mem_rdata;
          wb_d.mem_to_reg = ex_mem_read;
          state_d         = IDLE;
        end else begin
          wb_d   = bubble(wb_q);
          tmr_en = 1'b1;
          if (tmr_expired) begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      default: begin
        // ERR (and the unused encoding) park here until reset
        stall_c = 1'b1;
        wb_d    = bubble(wb_q);
        state_d = ERR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wb_q    <= wb_d;
    end
  end

  assign mem.mem_req   = (state_q == ACCESS);
  assign mem.mem_wr    = wr_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign stall         = stall_c & ~rst;
  assign err           = err_q;
  assign wb_valid      = wb_q.valid;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_halt       = wb_q.halt;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_wr_reg     = wb_q.wr_reg;
  assign wb_alu        = wb_q.alu;
  assign wb_rdata      = wb_q.rdata;
  assign fwd_data      = wb_q.mem_to_reg ? wb_q.rdata : wb_q.alu;

endmodule
